uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each received character, plus its break flag, on the receiver's one-cycle valid strobe.
- Presents a show-ahead FIFO head to the peripheral register bus.
- Generates level-threshold, overrun and optional idle-timeout status for the UART interrupt.

Parameters:
- DATA_BITS, 8, payload width; matches the receiver payload width.
- DEPTH, 16, FIFO entries; power of two, 2..256.
- ADDR_BITS, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: character received (from receiver valid).
- rx_data  in  DATA_BITS  received character.
- rx_break  in  1  character was a BREAK.
- divider  in  10  clocks per bit, same value the receiver uses.
- rd_en  in  1  pop head entry (bus read of data register).
- flush  in  1  discard all entries.
- threshold  in  ADDR_BITS+1  level interrupt threshold; 0 disables.
- overrun_clr  in  1  clear sticky overrun.
- rd_data  out  DATA_BITS  head character; 0 when empty.
- rd_break  out  1  break flag of head entry; 0 when empty.
- empty  out  1  no entries.
- full  out  1  DEPTH entries.
- level  out  ADDR_BITS+1  entry count, 0..DEPTH.
- overrun  out  1  sticky: character dropped because full.
- timeout  out  1  idle-timeout flag.
- irq  out  1  interrupt request.

Behaviour:
- Reset (resetn low, asynchronous):
  - pointers = 0, level = 0; empty = 1, full = 0.
  - overrun = 0, timeout = 0, irq = 0; rd_data = 0, rd_break = 0.
  - Timeout counters = 0.
- Storage:
  - Each entry is {rx_break, rx_data}, DATA_BITS+1 wide.
  - Read and write pointers are ADDR_BITS wide and wrap naturally modulo DEPTH.
  - level is a separate counter.
- Push: rx_valid && !full → write at wptr, wptr+1, level+1 on the next clock.
- Pop: rd_en && !empty → rptr+1, level-1. rd_en while empty is ignored; no state change.
- Push and pop in the same cycle:
  - Not full: both happen, level unchanged.
  - Full: both happen, no overrun.
  - Empty: push only; the new entry appears at the head one cycle later.
- Overrun:
  - rx_valid && full && !rd_en → character dropped, overrun = 1.
  - overrun_clr clears it. A set in the same cycle as a clear wins.
- Flush:
  - Pointers and level go to 0, timeout cleared.
  - Highest priority: a push or pop in the same cycle is dropped.
  - overrun is unaffected.
- Read latency: show-ahead. rd_data/rd_break reflect mem[rptr] combinationally from registered state; valid in the cycle after the push that made the FIFO non-empty.
- Flag widths:
  - empty = (level == 0); full = (level == DEPTH).
  - level compares use ADDR_BITS+1 bits, unsigned.
- irq = (threshold != 0 && level >= threshold) || overrun || timeout. Registered, 1 cycle after the cause.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - Bit-tick counter (10 bit) counts 0..divider; each wrap increments a 6-bit bit-period counter.
  - Both counters run only while !empty.
  - Both reset to 0 on rx_valid, rd_en, flush, or empty.
  - When the bit-period counter reaches 40 (4 character times), timeout is set; it stays set until rd_en, rx_valid or flush.
  - divider == 0: counters held at 0; timeout never set.
- Not defined:
  - No counters are built; timeout is tied to 0.
  - divider input is unused; the port remains.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_BITS = 8.
  - UART_TIMEOUT_BITS = 40.
  - Entry struct/typedef {brk, data}.
- One sub-module, uart_fifo_mem: simple dual-port register array, DATA_BITS+1 wide, DEPTH deep. Synchronous write; asynchronous read at rptr.
- Pointer/flag/timeout logic stays in uart_rx_fifo.

Test Plan:
1. Push 0x41, 0x42, 0x43, one cycle apart, then pop three times → rd_data 0x41, 0x42, 0x43 in order; level 3→0; empty = 1; no irq (threshold 0).
2. DEPTH=16: push 17 characters without reading → full = 1 after the 16th; 17th dropped; overrun = 1; irq = 1. Pop yields 16 characters in push order. overrun_clr → overrun = 0.
3. Full FIFO with rx_valid and rd_en in the same cycle → head popped, new character stored, level stays 16, overrun stays 0.
4. threshold = 4: push 3 → irq = 0; push 4th → irq = 1 the next cycle; one pop → irq = 0.
5. rx_break = 1 with rx_data = 0x00 pushed, then flush asserted in the same cycle as a further rx_valid → after the flush, empty = 1, level = 0, second character absent, rd_break = 0.
6. UART_RX_TIMEOUT_EN, divider = 10: push 1 character, then idle → timeout = 1 after 40×11 = 440 clocks, irq = 1. rd_en clears timeout. Without the macro, timeout stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and the receive-FIFO entry layout for the UART receive path.
package uart_pkg;

  // Payload width delivered by the UART receiver.
  localparam int UART_DATA_BITS = 8;

  // Idle bit periods (four 10-bit character times) before the receive timeout fires.
  localparam int UART_TIMEOUT_BITS = 40;

  // One FIFO entry: break flag above the received character.
  typedef struct packed {
    logic                      brk;
    logic [UART_DATA_BITS-1:0] data;
  } uart_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port register array with synchronous write and
// asynchronous read, used as the receive FIFO storage.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH     = UART_DATA_BITS + 1,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store the entry at the write pointer on the clock edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port is combinational so the FIFO head is visible without a read cycle.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO behind the UART receiver, with level
// threshold, sticky overrun and interrupt generation.
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle-timeout counters;
// without it timeout is tied low and divider is unused.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_break,
  input  logic [9:0]           divider,
  input  logic                 rd_en,
  input  logic                 flush,
  input  logic [ADDR_BITS:0]   threshold,
  input  logic                 overrun_clr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_break,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   level,
  output logic                 overrun,
  output logic                 timeout,
  output logic                 irq
);

  localparam logic [ADDR_BITS:0]   FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   LEVEL_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] r_wptr;
  logic [ADDR_BITS-1:0] r_rptr;
  logic [ADDR_BITS:0]   r_level;
  logic                 r_overrun;
  logic                 r_irq;
  logic                 w_timeout;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovr_set;
  logic [DATA_BITS:0]   w_wr_entry;
  logic [DATA_BITS:0]   w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LEVEL);

  // A full FIFO still accepts a character when the head is popped in the same cycle;
  // flush overrides both directions.
  assign w_pop     = !flush && rd_en && !w_empty;
  assign w_push    = !flush && rx_valid && (!w_full || rd_en);
  assign w_ovr_set = rx_valid && w_full && !rd_en;

  assign w_wr_entry = {rx_break, rx_data};

  uart_fifo_mem #(
    .WIDTH    (DATA_BITS + 1),
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_push),
    .i_waddr(r_wptr),
    .i_wdata(w_wr_entry),
    .i_raddr(r_rptr),
    .o_rdata(w_head)
  );

  // Pointer and level bookkeeping; flush returns everything to the empty state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_level <= r_level + LEVEL_ONE;
      else if (!w_push && w_pop) r_level <= r_level - LEVEL_ONE;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          r_overrun <= 1'b0;
    else if (w_ovr_set)   r_overrun <= 1'b1;
    else if (overrun_clr) r_overrun <= 1'b0;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [5:0] TO_LAST = 6'(UART_TIMEOUT_BITS - 1);
  localparam logic [5:0] TO_MAX  = 6'(UART_TIMEOUT_BITS);

  logic [9:0] r_tick;
  logic [5:0] r_bits;
  logic       r_timeout;
  logic       w_to_clr;
  logic       w_cnt_hold;
  logic       w_wrap;
  logic       w_to_set;

  assign w_to_clr   = rx_valid || rd_en || flush;
  assign w_cnt_hold = w_to_clr || w_empty || (divider == '0);
  assign w_wrap     = (r_tick >= divider);
  assign w_to_set   = !w_cnt_hold && w_wrap && (r_bits == TO_LAST);

  // Idle timers: ticks span divider+1 clocks per bit; bit count saturates at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick <= '0;
      r_bits <= '0;
    end else if (w_cnt_hold) begin
      r_tick <= '0;
      r_bits <= '0;
    end else if (w_wrap) begin
      r_tick <= '0;
      if (r_bits != TO_MAX) r_bits <= r_bits + 6'd1;
    end else begin
      r_tick <= r_tick + 10'd1;
    end
  end

  // Timeout flag: set on the last bit-period wrap, cleared by any FIFO activity.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_timeout <= 1'b0;
    else if (w_to_clr) r_timeout <= 1'b0;
    else if (w_to_set) r_timeout <= 1'b1;
  end

  assign w_timeout = r_timeout;
`else
  logic w_unused_divider;
  assign w_unused_divider = ^divider;
  assign w_timeout        = 1'b0;
`endif

  // Interrupt is registered from the current status, so it follows its cause by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_irq <= 1'b0;
    else         r_irq <= ((threshold != '0) && (r_level >= threshold)) || r_overrun || w_timeout;
  end

  assign rd_data  = w_empty ? '0 : w_head[DATA_BITS-1:0];
  assign rd_break = w_empty ? 1'b0 : w_head[DATA_BITS];
  assign empty    = w_empty;
  assign full     = w_full;
  assign level    = r_level;
  assign overrun  = r_overrun;
  assign timeout  = w_timeout;
  assign irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized stimulus for uart_rx_fifo, checked against a
// queue-based reference model with a scoreboard that compares every popped entry.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DATA_BITS = UART_DATA_BITS;
  localparam int DEPTH     = 16;
  localparam int ADDR_BITS = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 rx_valid = 1'b0;
  logic [DATA_BITS-1:0] rx_data = '0;
  logic                 rx_break = 1'b0;
  logic [9:0]           divider = '0;
  logic                 rd_en = 1'b0;
  logic                 flush = 1'b0;
  logic [ADDR_BITS:0]   threshold = '0;
  logic                 overrun_clr = 1'b0;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_break;
  logic                 empty;
  logic                 full;
  logic [ADDR_BITS:0]   level;
  logic                 overrun;
  logic                 timeout;
  logic                 irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .divider    (divider),
    .rd_en      (rd_en),
    .flush      (flush),
    .threshold  (threshold),
    .overrun_clr(overrun_clr),
    .rd_data    (rd_data),
    .rd_break   (rd_break),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overrun    (overrun),
    .timeout    (timeout),
    .irq        (irq)
  );

  int n_err    = 0;
  int n_checks = 0;
  int n_pops   = 0;

  // Reference model state
  uart_entry_t sb_q[$];
  int m_level = 0;
  bit m_ovr   = 1'b0;
  bit m_to    = 1'b0;
  bit m_irq   = 1'b0;
  int m_idle  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: applies the FIFO rules to the inputs sampled at each rising edge.
  always @(posedge clk) begin
    bit          pop_ok;
    bit          push_ok;
    bit          ovr_set;
    bit          new_irq;
    uart_entry_t e;
    if (!resetn) begin
      m_level = 0; m_ovr = 0; m_to = 0; m_irq = 0; m_idle = 0;
      sb_q.delete();
    end else begin
      new_irq = ((threshold != 0) && (m_level >= threshold)) || m_ovr || m_to;
      pop_ok  = !flush && rd_en && (m_level > 0);
      push_ok = !flush && rx_valid && ((m_level < DEPTH) || rd_en);
      ovr_set = rx_valid && (m_level == DEPTH) && !rd_en;
`ifdef UART_RX_TIMEOUT_EN
      if (rx_valid || rd_en || flush || (m_level == 0) || (divider == 0)) m_idle = 0;
      else m_idle++;
      if (rx_valid || rd_en || flush) m_to = 0;
      else if ((divider != 0) && (m_idle == UART_TIMEOUT_BITS * (int'(divider) + 1))) m_to = 1;
`endif
      if (ovr_set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (flush) begin
        m_level = 0;
        sb_q.delete();
      end else begin
        if (push_ok) begin
          e.brk  = rx_break;
          e.data = rx_data;
          sb_q.push_back(e);
        end
        m_level = m_level + int'(push_ok) - int'(pop_ok);
      end
      m_irq = new_irq;
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each accepted read.
  always @(negedge clk) begin
    uart_entry_t exp_e;
    chk("level", 32'(level), 32'(m_level));
    chk("empty", 32'(empty), 32'(m_level == 0));
    chk("full", 32'(full), 32'(m_level == DEPTH));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("irq", 32'(irq), 32'(m_irq));
    if (m_level == 0) begin
      chk("empty_rd_data", 32'(rd_data), 32'h0);
      chk("empty_rd_break", 32'(rd_break), 32'h0);
    end
    if (resetn && rd_en && !flush && (m_level > 0)) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_e = sb_q.pop_front();
        n_pops++;
        $display("pop %0d: data=0x%02h brk=%0d (expected 0x%02h brk=%0d)",
                 n_pops, rd_data, rd_break, exp_e.data, exp_e.brk);
        chk("pop_entry", {23'd0, rd_break, rd_data}, {23'd0, exp_e});
      end
    end
  end

  task automatic step(input bit rv, input logic [7:0] d, input bit brk,
                      input bit rd, input bit fl, input bit oc);
    rx_valid = rv; rx_data = d; rx_break = brk;
    rd_en = rd; flush = fl; overrun_clr = oc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0; rx_break = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rvp;
    int rdp;
    // Reset state, sampled before the first clock edge
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_break", 32'(rd_break), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    idle(2);

    // 1: three characters in, three out, in order
    step(1, 8'h41, 0, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0, 0);
    step(1, 8'h43, 0, 0, 0, 0);
    chk("t1_level3", 32'(level), 32'd3);
    chk("t1_head", 32'(rd_data), 32'h41);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);
    chk("t1_level0", 32'(level), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    idle(1);
    chk("t1_irq", 32'(irq), 32'd0);

    // 2: overfill by one
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 0);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_overrun_pre", 32'(overrun), 32'd0);
    step(1, 8'hEE, 0, 0, 0, 0);
    chk("t2_overrun", 32'(overrun), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
    idle(1);
    chk("t2_irq", 32'(irq), 32'd1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("t2_overrun_clr", 32'(overrun), 32'd0);

    // 3: full FIFO, simultaneous push and pop
    step(1, 8'hAA, 1, 1, 0, 0);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 0, 1, 0, 0);
    chk("t3_drained", 32'(empty), 32'd1);

    // 4: threshold interrupt
    threshold = 5'd4;
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
    idle(1);
    chk("t4_irq_below", 32'(irq), 32'd0);
    step(1, 8'h63, 0, 0, 0, 0);
    chk("t4_irq_lag", 32'(irq), 32'd0);
    idle(1);
    chk("t4_irq_at", 32'(irq), 32'd1);
    step(0, 8'h00, 0, 1, 0, 0);
    idle(1);
    chk("t4_irq_after_pop", 32'(irq), 32'd0);
    step(0, 8'h00, 0, 0, 1, 0);
    threshold = '0;

    // 5: break entry, then flush beats a concurrent push
    step(1, 8'h00, 1, 0, 0, 0);
    chk("t5_brk_head", 32'(rd_break), 32'd1);
    step(1, 8'h55, 0, 0, 1, 0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_rd_break", 32'(rd_break), 32'd0);
    chk("t5_rd_data", 32'(rd_data), 32'd0);

    // 6: idle timeout
    divider = 10'd10;
    idle(1);
    step(1, 8'h77, 0, 0, 0, 0);
`ifdef UART_RX_TIMEOUT_EN
    idle(439);
    chk("t6_timeout_early", 32'(timeout), 32'd0);
    idle(1);
    chk("t6_timeout", 32'(timeout), 32'd1);
    idle(1);
    chk("t6_irq", 32'(irq), 32'd1);
    step(0, 8'h00, 0, 1, 0, 0);
    chk("t6_timeout_clr", 32'(timeout), 32'd0);
    divider = 10'd1;
`else
    idle(500);
    chk("t6_timeout_off", 32'(timeout), 32'd0);
    step(0, 8'h00, 0, 1, 0, 0);
    divider = 10'(($urandom % 1023) + 1);
`endif
    idle(2);

    // Randomized traffic in segments with differing fill/drain bias
    for (int seg = 0; seg < 24; seg++) begin
      case ($urandom_range(0, 3))
        0: begin rvp = 60; rdp = 20; end
        1: begin rvp = 20; rdp = 60; end
        2: begin rvp = 40; rdp = 40; end
        default: begin rvp = 0; rdp = 0; end
      endcase
      threshold = 5'($urandom_range(0, DEPTH));
      for (int c = 0; c < 100; c++) begin
        step($urandom_range(0, 99) < rvp, 8'($urandom), $urandom_range(0, 7) == 0,
             $urandom_range(0, 99) < rdp, $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 5);
      end
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
